// File: rtl/cardinal_isa_pkg.sv
// Shared ISA encodings and pipeline register layouts for the four-stage vector core.
// Buses use big-endian bit numbering: bit 0 is the MSB.
package cardinal_isa_pkg;

   localparam logic [0:5] R_TYPE = 6'b101010;
   localparam logic [0:5] VLD    = 6'b100000;
   localparam logic [0:5] VSD    = 6'b100001;
   localparam logic [0:5] VBEZ   = 6'b100010;
   localparam logic [0:5] VBNEZ  = 6'b100011;
   localparam logic [0:5] VNOP   = 6'b111100;

   localparam logic [0:5] F_AND = 6'b000001;
   localparam logic [0:5] F_OR  = 6'b000010;
   localparam logic [0:5] F_XOR = 6'b000011;
   localparam logic [0:5] F_NOT = 6'b000100;
   localparam logic [0:5] F_MOV = 6'b000101;
   localparam logic [0:5] F_ADD = 6'b000110;
   localparam logic [0:5] F_SUB = 6'b000111;
   localparam logic [0:5] F_SLL = 6'b001010;
   localparam logic [0:5] F_SRL = 6'b001011;
   localparam logic [0:5] F_SRA = 6'b001100;

   localparam logic [0:1] WW_8  = 2'b00;
   localparam logic [0:1] WW_16 = 2'b01;
   localparam logic [0:1] WW_32 = 2'b10;
   localparam logic [0:1] WW_64 = 2'b11;

   typedef struct packed {
      logic        valid;
      logic [0:31] inst;
   } if_id_t;

   typedef struct packed {
      logic        wr_en;
      logic        mem_rd;
      logic        mem_wr;
      logic [0:4]  rd;
      logic [0:4]  ra;
      logic [0:4]  rb;
      logic [0:63] a;
      logic [0:63] b;
      logic [0:63] d;
      logic [0:15] imm;
      logic [0:1]  ww;
      logic [0:5]  func;
   } id_ex_t;

   typedef struct packed {
      logic        wr_en;
      logic        load;
      logic [0:4]  rd;
      logic [0:63] result;
   } ex_wb_t;

   function automatic logic func_defined(input logic [0:5] f);
      return f inside {F_AND, F_OR, F_XOR, F_NOT, F_MOV, F_ADD, F_SUB, F_SLL, F_SRL, F_SRA};
   endfunction

endpackage

// File: rtl/four_stage_vector_core_vector_alu.sv
// Combinational 64-bit SIMD ALU; lanes of 8/16/32/64 bits, no carries or shifts cross lanes.
module vector_alu
   import cardinal_isa_pkg::*;
(
   input  logic [0:63] a,
   input  logic [0:63] b,
   input  logic [0:1]  ww,
   input  logic [0:5]  func,
   output logic [0:63] result
);

   // x and y arrive zero-extended to 64 bits; w is the lane width
   function automatic logic [63:0] lane_op(input logic [63:0] x, input logic [63:0] y,
                                           input logic [0:5] f, input int w);
      logic [63:0] mask;
      logic [63:0] sx;
      logic [5:0]  sh;
      logic [63:0] r;
      mask = (64'd1 << w) - 64'd1;
      sh   = y[5:0] & 6'(w - 1);
      sx   = ((x & (mask ^ (mask >> 1))) != '0) ? (x | ~mask) : x;
      case (f)
         F_AND:   r = x & y;
         F_OR:    r = x | y;
         F_XOR:   r = x ^ y;
         F_NOT:   r = ~x;
         F_ADD:   r = x + y;
         F_SUB:   r = x - y;
         F_SLL:   r = x << sh;
         F_SRL:   r = x >> sh;
         F_SRA:   r = $signed(sx) >>> sh;
         default: r = x;
      endcase
      return r & mask;
   endfunction

   logic [63:0] av;
   logic [63:0] bv;
   logic [63:0] rv;

   always_comb begin
      av = a;
      bv = b;
      rv = '0;
      case (ww)
         WW_8:
            for (int i = 0; i < 8; i++)
               rv[i*8 +: 8] = 8'(lane_op({56'b0, av[i*8 +: 8]}, {56'b0, bv[i*8 +: 8]}, func, 8));
         WW_16:
            for (int i = 0; i < 4; i++)
               rv[i*16 +: 16] = 16'(lane_op({48'b0, av[i*16 +: 16]}, {48'b0, bv[i*16 +: 16]}, func, 16));
         WW_32:
            for (int i = 0; i < 2; i++)
               rv[i*32 +: 32] = 32'(lane_op({32'b0, av[i*32 +: 32]}, {32'b0, bv[i*32 +: 32]}, func, 32));
         default:
            rv = lane_op(av, bv, func, 64);
      endcase
      result = rv;
   end

endmodule

// File: rtl/four_stage_vector_core.sv
// Four-stage (IF, ID, EX/MEM, WB) in-order vector core with WB forwarding and ID branch resolution.
// Register file is write-through so ID sees the value being written back in the same cycle.
module four_stage_vector_core
   import cardinal_isa_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [0:31] inst_in,
   input  logic [0:63] d_in,
   output logic [0:31] pc_out,
   output logic [0:63] d_out,
   output logic [0:31] addr_out,
   output logic        memWrEn,
   output logic        memEn
);

   logic [0:31] pc;
   if_id_t      if_id;
   id_ex_t      id_ex;
   id_ex_t      id_next;
   ex_wb_t      ex_wb;
   ex_wb_t      ex_next;
   logic [0:63] rf [0:31];
   logic [0:63] wb_data;

   assign wb_data = ex_wb.load ? d_in : ex_wb.result;

   function automatic logic [0:63] read_reg(input logic [0:4] idx);
      if (idx == '0)
         return '0;
      else if (ex_wb.wr_en && ex_wb.rd == idx)
         return wb_data;
      else
         return rf[idx];
   endfunction

   logic [0:5]  id_op;
   logic [0:5]  id_fn;
   logic [0:4]  id_rd;
   logic [0:4]  id_ra;
   logic [0:4]  id_rb;
   logic [0:15] id_imm;
   logic [0:63] id_d;
   logic        id_unused;
   logic        id_ld;
   logic        id_st;
   logic        id_br;
   logic        stall;
   logic        taken;

   assign id_op     = if_id.inst[0:5];
   assign id_rd     = if_id.inst[6:10];
   assign id_ra     = if_id.inst[11:15];
   assign id_rb     = if_id.inst[16:20];
   assign id_fn     = if_id.inst[26:31];
   assign id_imm    = if_id.inst[16:31];
   assign id_unused = ^if_id.inst[21:23];
   assign id_d      = read_reg(id_rd);

   always_comb begin
      id_ld   = if_id.valid && id_op == VLD;
      id_st   = if_id.valid && id_op == VSD;
      id_br   = if_id.valid && (id_op == VBEZ || id_op == VBNEZ);
      // the branch operand would only exist after EX retires, so wait one cycle for write-through
      stall   = id_br && id_ex.wr_en && id_ex.rd == id_rd;
      taken   = id_br && !stall && ((id_op == VBEZ) ? (id_d == '0) : (id_d != '0));
      id_next = '0;
      if (!stall) begin
         id_next.wr_en  = (id_ld || (if_id.valid && id_op == R_TYPE && func_defined(id_fn)))
                          && id_rd != '0;
         id_next.mem_rd = id_ld;
         id_next.mem_wr = id_st;
         id_next.rd     = id_rd;
         id_next.ra     = id_ra;
         id_next.rb     = id_rb;
         id_next.a      = read_reg(id_ra);
         id_next.b      = read_reg(id_rb);
         id_next.d      = id_d;
         id_next.imm    = id_imm;
         id_next.ww     = if_id.inst[24:25];
         id_next.func   = id_fn;
      end
   end

   logic [0:63] ex_a;
   logic [0:63] ex_b;
   logic [0:63] ex_d;
   logic [0:63] alu_res;

   assign ex_a = (ex_wb.wr_en && ex_wb.rd == id_ex.ra) ? wb_data : id_ex.a;
   assign ex_b = (ex_wb.wr_en && ex_wb.rd == id_ex.rb) ? wb_data : id_ex.b;
   assign ex_d = (ex_wb.wr_en && ex_wb.rd == id_ex.rd) ? wb_data : id_ex.d;

   vector_alu u_alu (
      .a      (ex_a),
      .b      (ex_b),
      .ww     (id_ex.ww),
      .func   (id_ex.func),
      .result (alu_res)
   );

   always_comb begin
      ex_next        = '0;
      ex_next.wr_en  = id_ex.wr_en;
      ex_next.load   = id_ex.mem_rd;
      ex_next.rd     = id_ex.rd;
      ex_next.result = alu_res;
   end

   assign pc_out   = pc;
   assign memEn    = id_ex.mem_rd | id_ex.mem_wr;
   assign memWrEn  = id_ex.mem_wr;
   assign addr_out = memEn ? {16'b0, id_ex.imm} : '0;
   assign d_out    = id_ex.mem_wr ? ex_d : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= '0;
         if_id <= '0;
         id_ex <= '0;
         ex_wb <= '0;
      end else begin
         if (!stall) begin
            pc    <= taken ? {16'b0, id_imm} : pc + 32'd4;
            if_id <= taken ? '0 : {1'b1, inst_in};
         end
         id_ex <= id_next;
         ex_wb <= ex_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (ex_wb.wr_en) begin
         rf[ex_wb.rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_four_stage_vector_core.sv
// Directed programs with hand-computed results for the four-stage vector core.
module tb_four_stage_vector_core;

   localparam logic [5:0] OP_R  = 6'b101010;
   localparam logic [5:0] OP_LD = 6'b100000;
   localparam logic [5:0] OP_SD = 6'b100001;
   localparam logic [5:0] OP_BZ = 6'b100010;
   localparam logic [5:0] OP_BN = 6'b100011;
   localparam logic [1:0] B8 = 2'b00, H16 = 2'b01, W32 = 2'b10, D64 = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [0:31] inst_in;
   logic [0:63] d_in = '0;
   logic [0:31] pc_out;
   logic [0:63] d_out;
   logic [0:31] addr_out;
   logic        memWrEn;
   logic        memEn;

   logic [0:31] imem [0:255];
   logic [0:63] dmem [0:255];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [0:63] ld_data = '0;
   int          wr_count = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          pidx;

   always #5 clk = ~clk;

   assign inst_in = imem[pc_out[22:29]];

   four_stage_vector_core dut (
      .clk      (clk),
      .reset    (reset),
      .inst_in  (inst_in),
      .d_in     (d_in),
      .pc_out   (pc_out),
      .d_out    (d_out),
      .addr_out (addr_out),
      .memWrEn  (memWrEn),
      .memEn    (memEn)
   );

   always @(posedge clk) begin
      if (ld_en)
         dmem[ld_addr] <= ld_data;
      else if (memEn) begin
         if (memWrEn) begin
            dmem[addr_out[24:31]] <= d_out;
            wr_count <= wr_count + 1;
         end else
            d_in <= dmem[addr_out[24:31]];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rd, input int ra, input int rb,
                                         input logic [1:0] ww, input logic [5:0] fn);
      return {OP_R, 5'(rd), 5'(ra), 5'(rb), 3'b000, ww, fn};
   endfunction

   function automatic logic [31:0] enc_m(input logic [5:0] op, input int rd, input int imm);
      return {op, 5'(rd), 5'd0, 16'(imm)};
   endfunction

   task automatic put(input logic [31:0] w);
      imem[pidx] = w;
      pidx++;
   endtask

   task automatic poke(input int a, input logic [63:0] v);
      @(negedge clk);
      ld_addr = 8'(a);
      ld_data = v;
      ld_en   = 1'b1;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // asserted off-edge: the core must clear without waiting for a clock
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("rst_pc", 64'(pc_out), 64'h0);
      check_val("rst_memen", 64'(memEn), 64'h0);
      for (int i = 0; i < 256; i++) imem[i] = '0;
      pidx = 0;
   endtask

   task automatic release_run(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   int w0;
   logic [31:0] exp_pc [0:11];

   initial begin
      // reset with an empty program: PC free-runs, no memory traffic
      do_reset();
      check_val("rst_wren", 64'(memWrEn), 64'h0);
      check_val("rst_dout", d_out, 64'h0);
      check_val("rst_addr", 64'(addr_out), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      check_val("pc_c0", 64'(pc_out), 64'h0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         check_val("pc_step", 64'(pc_out), 64'(4 * k));
         check_val("idle_memen", 64'(memEn), 64'h0);
      end

      // load/store round trip with 32-bit lane carry discarded
      do_reset();
      put(enc_m(OP_LD, 1, 0));
      put(enc_m(OP_LD, 2, 1));
      put(enc_r(3, 1, 2, W32, 6'b000110));
      put(enc_m(OP_SD, 3, 2));
      poke(0, 64'h00000001_FFFFFFFF);
      poke(1, 64'h00000001_00000001);
      poke(2, 64'hDEAD);
      w0 = wr_count;
      release_run(14);
      check_val("ldst_dmem2", dmem[2], 64'h00000002_00000000);
      check_val("ldst_wrcnt", 64'(wr_count - w0), 64'd1);

      // back-to-back load-use with forwarding
      do_reset();
      put(enc_m(OP_LD, 1, 0));
      put(enc_r(4, 1, 1, B8, 6'b000111));
      put(enc_m(OP_SD, 4, 3));
      put(enc_m(OP_LD, 6, 1));
      put(enc_r(7, 6, 6, D64, 6'b000110));
      put(enc_m(OP_SD, 7, 4));
      poke(3, 64'hDEAD);
      poke(4, 64'hBEEF);
      release_run(14);
      check_val("fwd_sub_b", dmem[3], 64'h0);
      check_val("fwd_add_d", dmem[4], 64'h00000002_00000002);

      // lane shifts and logic ops, plus an undefined func
      do_reset();
      put(enc_m(OP_LD, 1, 0));
      put(enc_m(OP_LD, 2, 1));
      put(enc_r(3, 1, 2, H16, 6'b001100));
      put(enc_r(4, 1, 2, D64, 6'b001010));
      put(enc_r(5, 1, 2, B8,  6'b001011));
      put(enc_r(6, 1, 2, D64, 6'b000011));
      put(enc_r(7, 1, 0, H16, 6'b000100));
      put(enc_r(8, 1, 2, W32, 6'b000001));
      put(enc_r(9, 1, 2, D64, 6'b111111));
      for (int r = 3; r <= 9; r++) put(enc_m(OP_SD, r, r - 1));
      poke(0, 64'h8000_0000_0000_0001);
      poke(1, 64'h0001_0001_0001_0001);
      poke(8, 64'h1234);
      release_run(24);
      check_val("sra_h", dmem[2], 64'hC000_0000_0000_0000);
      check_val("sll_d", dmem[3], 64'h0000_0000_0000_0002);
      check_val("srl_b", dmem[4], 64'h8000_0000_0000_0000);
      check_val("xor_d", dmem[5], 64'h8001_0001_0001_0000);
      check_val("not_h", dmem[6], 64'h7FFF_FFFF_FFFF_FFFE);
      check_val("and_w", dmem[7], 64'h0000_0000_0000_0001);
      check_val("undef_fn", dmem[8], 64'h0);

      // branches: stall on EX hazard, squash fall-through, not-taken VBEZ, taken VBEZ on r0
      do_reset();
      imem[0]  = enc_m(OP_LD, 2, 0);
      imem[1]  = 32'hF000_0000;
      imem[2]  = enc_r(1, 2, 2, D64, 6'b000110);
      imem[3]  = enc_m(OP_BN, 1, 32'h40);
      imem[4]  = enc_m(OP_SD, 2, 7);
      imem[16] = enc_m(OP_BZ, 1, 32'h80);
      imem[17] = enc_m(OP_SD, 1, 8);
      imem[18] = enc_m(OP_BZ, 0, 32'h60);
      imem[19] = enc_m(OP_SD, 1, 9);
      imem[24] = enc_m(OP_SD, 1, 10);
      poke(0, 64'h5);
      poke(7, 64'h7777);
      poke(9, 64'h9999);
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h40, 32'h44,
                 32'h48, 32'h4C, 32'h60, 32'h64};
      w0 = wr_count;
      @(negedge clk);
      reset = 1'b0;
      check_val("br_pc0", 64'(pc_out), 64'(exp_pc[0]));
      for (int k = 1; k < 12; k++) begin
         @(posedge clk);
         #1;
         check_val("br_pc", 64'(pc_out), 64'(exp_pc[k]));
      end
      repeat (6) @(posedge clk);
      #1;
      check_val("br_squash7", dmem[7], 64'h7777);
      check_val("br_fallthru", dmem[8], 64'hA);
      check_val("br_squash9", dmem[9], 64'h9999);
      check_val("br_target", dmem[10], 64'hA);
      check_val("br_wrcnt", 64'(wr_count - w0), 64'd2);

      // register 0 discards writes
      do_reset();
      put(enc_m(OP_LD, 1, 0));
      put(enc_r(0, 1, 1, D64, 6'b000110));
      put(enc_m(OP_SD, 0, 5));
      put(enc_m(OP_SD, 1, 6));
      poke(0, 64'h0123_4567_89AB_CDEF);
      poke(5, 64'h5555);
      release_run(12);
      check_val("r0_store", dmem[5], 64'h0);
      check_val("r1_store", dmem[6], 64'h0123_4567_89AB_CDEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/four_stage_vector_core.md
Name: four_stage_vector_core

Overview:
- 4-stage in-order pipelined CPU core: IF, ID, EX/MEM, WB.
- 32-bit instructions, 64-bit datapath, 32x64-bit register file, SIMD lane-width ALU.
- Sits between an external combinational instruction memory (imem) and a synchronous data memory (dmem) in the CPU tile.
- All buses use big-endian bit numbering [0:N]; bit 0 is the MSB.

Parameters:
- none; widths are fixed by the ISA.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; one clock domain.
- inst_in  input  32  instruction from imem at pc_out (combinational).
- d_in  input  64  dmem read data, valid the cycle after a read is issued.
- pc_out  output  32  fetch byte address; imem word index = pc_out[22:29].
- d_out  output  64  store data.
- addr_out  output  32  data address {16'b0, imm16}; dmem word index = addr_out[24:31].
- memWrEn  output  1  write strobe (store).
- memEn  output  1  memory access enable (load or store).

Behaviour:
- Reset (async): PC=0; all pipeline registers hold bubbles; all 32 registers = 0; pc_out=0, memEn=0, memWrEn=0, d_out=0, addr_out=0.
- Instruction fields: opcode[0:5], rD[6:10], rA[11:15], rB[16:20], WW[24:25] (00=8b, 01=16b, 10=32b, 11=64b lanes), func[26:31], imm[16:31].
- Bits [21:23] are reserved and ignored.
- R-type (opcode 101010), result to rD, per-lane, no carries across lanes:
  - func 000001 AND, 000010 OR, 000011 XOR, 000100 NOT rA, 000101 MOV rA.
  - func 000110 ADD mod 2^lane, 000111 SUB mod 2^lane.
  - func 001010 SLL, 001011 SRL, 001100 SRA: shift amount = low log2(lane) bits of the matching rB lane.
  - Undefined func is a no-op.
- VLD (100000): rD <= dmem[imm].
- VSD (100001): dmem[imm] <= rD.
- VBEZ (100010): branch to PC=imm if rD==0.
- VBNEZ (100011): branch to PC=imm if rD!=0.
- VNOP (111100) and any undefined opcode, including 0x00000000 (end-of-program marker), cause no architectural effect.
- Register 0 reads as 0; writes to it are discarded.
- PC += 4 each cycle unless stalled or branch taken.
- Branches resolve in ID:
  - Taken: PC <= imm next edge; the instruction in IF is squashed (1-cycle penalty).
  - Not-taken: no penalty.
- EX/MEM stage:
  - ALU executes.
  - For load/store, memEn=1 and addr_out is driven in the same cycle.
  - For a store, memWrEn=1 and d_out = rD value.
  - Otherwise memEn=memWrEn=0.
- WB stage:
  - Writes ALU result, or d_in for a load, on the rising edge.
  - The register file is write-through: a same-cycle read of the written register returns the new value.
- Forwarding: the WB result is forwarded to EX operands (rA, rB, store data) when WB.rD matches and is nonzero.
- Branch hazard: if the instruction in EX writes the branch's rD, ID and IF stall 1 cycle (bubble inserted into EX); the value then arrives via write-through.
- Loads need no EX stall: load data is forwarded from WB.
- Reset mid-program: immediate asynchronous return to the reset state; in-flight instructions are discarded.

Decomposition:
- Shared package `cardinal_isa_pkg`:
  - opcode constants (R_TYPE, VLD, VSD, VBEZ, VBNEZ, VNOP);
  - func constants;
  - WW encodings;
  - pipeline-register struct typedefs.
- One natural sub-module: `vector_alu`, a combinational 64-bit lane-width ALU with inputs a, b, ww, func and output result.
- The register file and hazard logic stay inline.

Test Plan:
- Reset, then a program in which 0x00000000 is the first word → pc_out=0 during reset; pc_out steps 0,4,8…; no memEn pulse.
- Load/store round trip:
  - Program: VLD r1,0; VLD r2,1; VADD.w r3,r1,r2; VSD r3,2.
  - Data: dmem[0]=0x00000001_FFFFFFFF, dmem[1]=0x00000001_00000001.
  - Required: dmem[2]=0x00000002_00000000, with the 32-bit lane carry discarded.
- Back-to-back dependency:
  - Program: VLD r1,0 followed immediately by VSUB.b r4,r1,r1 and VSD r4,3.
  - Required: dmem[3]=0, with the forwarded operand used.
- Lane shifts:
  - Data: r1=0x8000_0000_0000_0001, r2=1 in every lane.
  - Required: VSRA.h gives 0xC000_0000_0000_0000; VSLL.d gives 0x0000_0000_0000_0002.
- Branches:
  - VBNEZ r1 with r1 = nonzero result of the preceding instruction: 1-cycle stall, then PC=imm; the squashed fall-through store must not write (memWrEn stays 0).
  - VBEZ on a nonzero register: falls through.
- Register 0: VADD r0,r1,r1 then VSD r0,5 → dmem[5]=0.
